// File: rtl/board_ram_arbiter.sv
// Board RAM arbiter: shares the single-port 256x6 board RAM among the game
// sub-modules (collision checker, add-to-RAM writer, VGA drawer, line-clear).
// Round-robin arbitration with optional locked bursts; read data is routed
// back to the issuing requester after RD_LATENCY cycles.
//
// Handshake: a requester holds req[i] (with we/addr/wdata/lock) high; an
// access takes place in every cycle where req[i] && gnt[i]. gnt is
// combinational from req, so dropping req drops gnt in the same cycle. Reads
// return as a one-cycle rvalid[i] pulse RD_LATENCY cycles after the access.
module board_ram_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int ADDR_W     = 8,
  parameter int DATA_W     = 6,
  parameter int RD_LATENCY = 1,
  parameter int MAX_BURST  = 16,
  localparam int PTR_W     = $clog2(NUM_REQ),
  localparam int CNT_W     = $clog2(MAX_BURST + 1)
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ-1:0]        we,
  input  logic [NUM_REQ-1:0]        lock,
  input  logic [NUM_REQ*ADDR_W-1:0] addr,
  input  logic [NUM_REQ*DATA_W-1:0] wdata,
  output logic [NUM_REQ-1:0]        gnt,
  output logic [NUM_REQ-1:0]        rvalid,
  output logic [DATA_W-1:0]         rdata,
  output logic [ADDR_W-1:0]         ram_addr,
  output logic [DATA_W-1:0]         ram_data,
  output logic                      ram_wren,
  input  logic [DATA_W-1:0]         ram_q,
  // {locked, ptr} for observing the arbiter state
  output logic [PTR_W:0]            dbg_state
);

  typedef enum logic {ARB = 1'b0, LOCKED = 1'b1} state_t;

  state_t             state;
  logic [PTR_W-1:0]   ptr;
  logic [PTR_W-1:0]   owner;
  logic [CNT_W-1:0]   burst_cnt;

  logic               win_found;
  logic [PTR_W-1:0]   win_id;
  int                 scan_idx;
  logic [NUM_REQ-1:0] gnt_c;
  logic [PTR_W-1:0]   sel_id;
  logic               granted;

  logic [RD_LATENCY-1:0] sr_vld;
  logic [PTR_W-1:0]      sr_id [RD_LATENCY];

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (int'(p) == NUM_REQ - 1) ? '0 : p + 1'b1;
  endfunction

  // Find the first requester at or after ptr, wrapping around
  always_comb begin
    win_found = 1'b0;
    win_id    = '0;
    scan_idx  = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      scan_idx = (int'(ptr) + k) % NUM_REQ;
      if (!win_found && req[scan_idx]) begin
        win_found = 1'b1;
        win_id    = PTR_W'(scan_idx);
      end
    end
  end

  // Grant: round-robin winner in ARB, the owner (while it requests) in LOCKED
  always_comb begin
    gnt_c = '0;
    if (state == ARB) begin
      if (win_found) gnt_c[win_id] = 1'b1;
    end else begin
      gnt_c[owner] = req[owner];
    end
  end

  assign gnt     = reset_n ? gnt_c : '0;
  assign sel_id  = (state == ARB) ? win_id : owner;
  assign granted = |gnt;

  // Route the granted requester onto the RAM port; idle port is all zeros
  always_comb begin
    ram_addr = '0;
    ram_data = '0;
    ram_wren = 1'b0;
    if (granted) begin
      ram_addr = addr[int'(sel_id)*ADDR_W +: ADDR_W];
      ram_data = wdata[int'(sel_id)*DATA_W +: DATA_W];
      ram_wren = we[sel_id];
    end
  end

  // Arbitration state machine: pointer rotation and locked-burst tracking
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= ARB;
      ptr       <= '0;
      owner     <= '0;
      burst_cnt <= '0;
    end else begin
      case (state)
        ARB: begin
          if (win_found) begin
            if (lock[win_id] && (MAX_BURST > 1)) begin
              state     <= LOCKED;
              owner     <= win_id;
              burst_cnt <= CNT_W'(1);
            end else begin
              ptr <= ptr_inc(win_id);
            end
          end
        end
        LOCKED: begin
          // The grant in this cycle is the last one when lock drops or the
          // burst limit is reached; a dropped req ends the burst ungranted.
          if (!req[owner] || !lock[owner] ||
              burst_cnt == CNT_W'(MAX_BURST - 1)) begin
            state     <= ARB;
            ptr       <= ptr_inc(owner);
            burst_cnt <= '0;
          end else begin
            burst_cnt <= burst_cnt + 1'b1;
          end
        end
        default: state <= ARB;
      endcase
    end
  end

  // Read-return pipe carrying {valid, requester id} alongside the RAM latency
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sr_vld <= '0;
      for (int i = 0; i < RD_LATENCY; i++) sr_id[i] <= '0;
    end else begin
      sr_vld[0] <= granted && !we[sel_id];
      sr_id[0]  <= sel_id;
      for (int i = RD_LATENCY - 1; i > 0; i--) begin
        sr_vld[i] <= sr_vld[i-1];
        sr_id[i]  <= sr_id[i-1];
      end
    end
  end

  // Decode the emerging pipe entry into a per-requester valid pulse
  always_comb begin
    rvalid = '0;
    if (sr_vld[RD_LATENCY-1]) rvalid[sr_id[RD_LATENCY-1]] = 1'b1;
  end

  assign rdata     = ram_q;
  assign dbg_state = {state == LOCKED, ptr};

endmodule

// File: tb/tb_board_ram_arbiter.sv
// Testbench for board_ram_arbiter: behavioural RAM, reference model of the
// arbitration rules and a read-return scoreboard.
module tb_board_ram_arbiter;

  localparam int N   = 4;
  localparam int AW  = 8;
  localparam int DW  = 6;
  localparam int LAT = 1;
  localparam int MB  = 16;
  localparam int PW  = 2;

  logic            clk;
  logic            reset_n;
  logic [N-1:0]    req, we, lock;
  logic [N*AW-1:0] addr;
  logic [N*DW-1:0] wdata;
  logic [N-1:0]    gnt, rvalid;
  logic [DW-1:0]   rdata, ram_data, ram_q;
  logic [AW-1:0]   ram_addr;
  logic            ram_wren;
  logic [PW:0]     dbg_state;

  board_ram_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW),
                      .RD_LATENCY(LAT), .MAX_BURST(MB)) dut (
    .clk(clk), .reset_n(reset_n), .req(req), .we(we), .lock(lock),
    .addr(addr), .wdata(wdata), .gnt(gnt), .rvalid(rvalid), .rdata(rdata),
    .ram_addr(ram_addr), .ram_data(ram_data), .ram_wren(ram_wren),
    .ram_q(ram_q), .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural board RAM, new-data-on-read-during-write, 1-cycle read
  logic [DW-1:0] mem [256];
  always @(posedge clk) begin
    if (ram_wren) mem[ram_addr] <= ram_data;
    ram_q <= ram_wren ? ram_data : mem[ram_addr];
  end

  // ---------------- reference model + scoreboard ----------------
  logic [DW-1:0] shadow [256];
  int            m_ptr;
  int            m_owner;     // -1 when not in a burst
  int            m_burst;
  int            cyc;
  logic [24:0]   exp_q [$];   // {due cycle[15:0], id[2:0], data[5:0]}
  int            n_vec, n_err;
  logic [N-1:0]  last_gnt;
  logic [AW-1:0] ta [N];
  logic [DW-1:0] td [N];

  task automatic check_val(input string tag, input logic [31:0] got,
                           input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic model_clear();
    m_ptr = 0; m_owner = -1; m_burst = 0;
    exp_q.delete();
  endtask

  // Drive one cycle of inputs, then check outputs against the model mid-cycle
  task automatic step_check(input logic [N-1:0] r, input logic [N-1:0] w,
                            input logic [N-1:0] l);
    int g;
    logic [N-1:0]  eg, erv;
    logic [24:0]   e;
    req = r; we = w; lock = l;
    for (int i = 0; i < N; i++) begin
      addr[i*AW +: AW]  = ta[i];
      wdata[i*DW +: DW] = td[i];
    end
    @(negedge clk);
    g = -1;
    if (m_owner >= 0) begin
      if (r[m_owner]) begin
        g = m_owner;
        m_burst++;
        if (!l[m_owner] || m_burst == MB) begin
          m_ptr = (m_owner + 1) % N; m_owner = -1;
        end
      end else begin
        m_ptr = (m_owner + 1) % N; m_owner = -1;
      end
    end else begin
      for (int k = 0; k < N; k++)
        if (g < 0 && r[(m_ptr + k) % N]) g = (m_ptr + k) % N;
      if (g >= 0) begin
        if (l[g] && MB > 1) begin m_owner = g; m_burst = 1; end
        else m_ptr = (g + 1) % N;
      end
    end
    eg = '0;
    if (g >= 0) eg[g] = 1'b1;
    last_gnt = gnt;
    check_val("gnt", 32'(gnt), 32'(eg));
    check_val("ram_wren", 32'(ram_wren), (g >= 0) ? 32'(w[g]) : 32'd0);
    check_val("ram_addr", 32'(ram_addr), (g >= 0) ? 32'(ta[g]) : 32'd0);
    check_val("ram_data", 32'(ram_data), (g >= 0) ? 32'(td[g]) : 32'd0);
    erv = '0;
    if (exp_q.size() > 0 && int'(exp_q[0][24:9]) == (cyc & 16'hFFFF)) begin
      e = exp_q.pop_front();
      erv[e[8:6]] = 1'b1;
      check_val("rdata", 32'(rdata), 32'(e[5:0]));
    end
    check_val("rvalid", 32'(rvalid), 32'(erv));
    if (g >= 0) begin
      if (w[g]) shadow[ta[g]] = td[g];
      else exp_q.push_back({16'(cyc + LAT), 3'(g), shadow[ta[g]]});
    end
    cyc++;
  endtask

  task automatic step(input logic [N-1:0] r, input logic [N-1:0] w,
                      input logic [N-1:0] l);
    step_check(r, w, l);
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    req = '0; we = '0; lock = '0; addr = '0; wdata = '0;
    model_clear();
    repeat (2) @(posedge clk);
    #1;
    check_val("rst_gnt", 32'(gnt), 32'd0);
    check_val("rst_wren", 32'(ram_wren), 32'd0);
    check_val("rst_addr", 32'(ram_addr), 32'd0);
    check_val("rst_data", 32'(ram_data), 32'd0);
    check_val("rst_rvalid", 32'(rvalid), 32'd0);
    check_val("rst_state", 32'(dbg_state), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk); #1;
  endtask

  // ---------------- stimulus ----------------
  int burst_hits;

  initial begin
    n_vec = 0; n_err = 0; cyc = 0;
    for (int i = 0; i < 256; i++) begin
      mem[i]    = 6'(i * 7 + 3);
      shadow[i] = 6'(i * 7 + 3);
    end
    mem[8'h25] = 6'h1A; shadow[8'h25] = 6'h1A;
    for (int i = 0; i < N; i++) begin ta[i] = '0; td[i] = '0; end
    do_reset();

    // Single read of preloaded cell 0x25
    ta[0] = 8'h25;
    step(4'b0001, 4'b0000, 4'b0000);
    step(4'b0000, 4'b0000, 4'b0000);

    // Rotation with all requesting, from ptr = 0
    do_reset();
    for (int i = 0; i < N; i++) ta[i] = 8'h80 + 8'(i);
    for (int k = 0; k < 5; k++) step(4'b1111, 4'($urandom_range(0, 15)), 4'b0000);

    // Locked write burst by requester 2, capped at MB grants
    do_reset();
    burst_hits = 0;
    ta[2] = 8'h00; td[2] = 6'h2A;
    step(4'b0100, 4'b0100, 4'b0100);
    if (last_gnt == 4'b0100) burst_hits++;
    for (int k = 1; k < MB + 1; k++) begin
      ta[2] = 8'(k); td[2] = 6'(k) ^ 6'h2A;
      step(4'b1111, 4'b0100, 4'b0100);
      if (last_gnt == 4'b0100) burst_hits++;
    end
    check_val("burst_len", 32'(burst_hits), 32'(MB));
    check_val("after_burst", 32'(last_gnt), 32'b1000);
    step(4'b0000, 4'b0000, 4'b0000);
    for (int i = 0; i < 16; i++)
      check_val("burst_mem", 32'(mem[i]), 32'(6'(i) ^ 6'h2A));

    // Write by 1 then read of same cell by 3 in the next cycle
    ta[1] = 8'h40; td[1] = 6'h07; ta[3] = 8'h40;
    step(4'b0010, 4'b0010, 4'b0000);
    step(4'b1000, 4'b0000, 4'b0000);
    step(4'b0000, 4'b0000, 4'b0000);

    // Three back-to-back reads by requester 0
    for (int k = 0; k < 3; k++) begin
      ta[0] = 8'h10 + 8'(k);
      step(4'b0001, 4'b0000, 4'b0000);
    end
    step(4'b0000, 4'b0000, 4'b0000);
    step(4'b0000, 4'b0000, 4'b0000);

    // Randomised traffic with occasional locks
    for (int k = 0; k < 400; k++) begin
      for (int i = 0; i < N; i++) begin
        ta[i] = 8'($urandom_range(0, 31));
        td[i] = 6'($urandom_range(0, 63));
      end
      step(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
           ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'b0000);
    end

    // Read in flight, reset asserted before the data returns
    step(4'b0000, 4'b0000, 4'b0000);
    step(4'b0000, 4'b0000, 4'b0000);
    ta[0] = 8'h33;
    step_check(4'b0001, 4'b0000, 4'b0000);
    reset_n = 1'b0;
    we = 4'b0001;
    #1;
    check_val("mid_rst_gnt", 32'(gnt), 32'd0);
    check_val("mid_rst_wren", 32'(ram_wren), 32'd0);
    check_val("mid_rst_ptr", 32'(dbg_state), 32'd0);
    model_clear();
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk); #1;
    for (int k = 0; k < 3; k++) step(4'b0000, 4'b0000, 4'b0000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
